// File: rtl/ibis_tmds_pkg.sv
// rtl/ibis_tmds_pkg.sv - shared TMDS types, control tokens and decoder state encoding
package ibis_tmds_pkg;

  typedef logic [9:0] tmds_word_t;

  localparam tmds_word_t CTRL_TOKEN_00 = 10'b1101010100;
  localparam tmds_word_t CTRL_TOKEN_01 = 10'b0010101011;
  localparam tmds_word_t CTRL_TOKEN_10 = 10'b0101010100;
  localparam tmds_word_t CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_HUNT      = 2'b00,
    ST_SLIP_WAIT = 2'b01,
    ST_LOCKED    = 2'b10
  } dec_state_e;

endpackage

// File: rtl/ibis_tmds_word_decode.sv
// rtl/ibis_tmds_word_decode.sv - combinational TMDS word classifier and 10b-to-8b data decoder
module ibis_tmds_word_decode
  import ibis_tmds_pkg::*;
(
  input  tmds_word_t  word,
  output logic        is_token,
  output logic [1:0]  token_value,
  output logic [7:0]  data
);

  logic [7:0] m;

  assign m = word[9] ? ~word[7:0] : word[7:0];

  always_comb begin
    is_token    = 1'b1;
    token_value = 2'b00;
    case (word)
      CTRL_TOKEN_00: token_value = 2'b00;
      CTRL_TOKEN_01: token_value = 2'b01;
      CTRL_TOKEN_10: token_value = 2'b10;
      CTRL_TOKEN_11: token_value = 2'b11;
      default:       is_token    = 1'b0;
    endcase
  end

  // bit 8 selects whether the encoder chained the byte with XOR or XNOR
  always_comb begin
    data    = 8'h00;
    data[0] = m[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = word[8] ? (m[i] ^ m[i-1]) : ~(m[i] ^ m[i-1]);
    end
  end

endmodule

// File: rtl/ibis_tmds_decoder.sv
// rtl/ibis_tmds_decoder.sv - per-lane TMDS word aligner and decoder with bit-slip hunting
module ibis_tmds_decoder
  import ibis_tmds_pkg::*;
#(
  parameter int LOCK_TOKENS  = 8,
  parameter int SLIP_TIMEOUT = 2048,
  parameter int SLIP_SETTLE  = 16,
  parameter int LOSS_TIMEOUT = 65536
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       enable,
  input  logic [9:0] in_parallel,
  output logic       bitslip,
  output logic       locked,
  output logic [7:0] data,
  output logic       data_enable,
  output logic [1:0] control,
  output logic [1:0] debug_state
);

  localparam int RUN_W    = (LOCK_TOKENS  > 1) ? $clog2(LOCK_TOKENS)  : 1;
  localparam int HUNT_W   = (SLIP_TIMEOUT > 1) ? $clog2(SLIP_TIMEOUT) : 1;
  localparam int SETTLE_W = (SLIP_SETTLE  > 1) ? $clog2(SLIP_SETTLE)  : 1;
  localparam int LOSS_W   = (LOSS_TIMEOUT > 1) ? $clog2(LOSS_TIMEOUT) : 1;

  logic       dec_is_token;
  logic [1:0] dec_token_value;
  logic [7:0] dec_data;

  ibis_tmds_word_decode u_word_decode (
    .word        (in_parallel),
    .is_token    (dec_is_token),
    .token_value (dec_token_value),
    .data        (dec_data)
  );

  logic       s1_tok_q;
  logic [1:0] s1_val_q;
  logic [7:0] s1_data_q;

  dec_state_e          state_q, state_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [HUNT_W-1:0]   hunt_q, hunt_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [LOSS_W-1:0]   loss_q, loss_d;

  logic       bitslip_q, bitslip_d;
  logic [7:0] data_q, data_d;
  logic       de_q, de_d;
  logic [1:0] ctrl_q, ctrl_d;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= ST_HUNT;
      run_q    <= '0;
      hunt_q   <= '0;
      settle_q <= '0;
      loss_q   <= '0;
    end else if (enable) begin
      state_q  <= state_d;
      run_q    <= run_d;
      hunt_q   <= hunt_d;
      settle_q <= settle_d;
      loss_q   <= loss_d;
    end
  end

  // Every transition lands on its terminal count, so no timer can wrap
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    hunt_d   = hunt_q;
    settle_d = settle_q;
    loss_d   = loss_q;
    case (state_q)
      ST_HUNT: begin
        run_d = s1_tok_q ? run_q + RUN_W'(1) : '0;
        if (s1_tok_q && (run_q == RUN_W'(LOCK_TOKENS - 1))) begin
          state_d = ST_LOCKED;
          run_d   = '0;
          hunt_d  = '0;
          loss_d  = '0;
        end else if (hunt_q == HUNT_W'(SLIP_TIMEOUT - 1)) begin
          state_d  = ST_SLIP_WAIT;
          run_d    = '0;
          hunt_d   = '0;
          settle_d = '0;
        end else begin
          hunt_d = hunt_q + HUNT_W'(1);
        end
      end
      ST_SLIP_WAIT: begin
        if (settle_q == SETTLE_W'(SLIP_SETTLE - 1)) begin
          state_d  = ST_HUNT;
          run_d    = '0;
          hunt_d   = '0;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      ST_LOCKED: begin
        if (s1_tok_q) begin
          loss_d = '0;
        end else if (loss_q == LOSS_W'(LOSS_TIMEOUT - 1)) begin
          state_d = ST_HUNT;
          run_d   = '0;
          hunt_d  = '0;
          loss_d  = '0;
        end else begin
          loss_d = loss_q + LOSS_W'(1);
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_comb begin
    bitslip_d = (state_q == ST_HUNT) && (state_d == ST_SLIP_WAIT);
    data_d    = 8'h00;
    de_d      = 1'b0;
    ctrl_d    = ctrl_q;
    if (state_q == ST_LOCKED) begin
      if (s1_tok_q) begin
        data_d = data_q;
        ctrl_d = s1_val_q;
      end else begin
        data_d = s1_data_q;
        de_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      s1_tok_q  <= 1'b0;
      s1_val_q  <= 2'b00;
      s1_data_q <= 8'h00;
      bitslip_q <= 1'b0;
      data_q    <= 8'h00;
      de_q      <= 1'b0;
      ctrl_q    <= 2'b00;
    end else if (enable) begin
      s1_tok_q  <= dec_is_token;
      s1_val_q  <= dec_token_value;
      s1_data_q <= dec_data;
      bitslip_q <= bitslip_d;
      data_q    <= data_d;
      de_q      <= de_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign bitslip     = bitslip_q;
  assign locked      = (state_q == ST_LOCKED);
  assign data        = data_q;
  assign data_enable = de_q;
  assign control     = ctrl_q;
  assign debug_state = state_q;

endmodule

// File: tb/tb_ibis_tmds_decoder.sv
// tb/tb_ibis_tmds_decoder.sv - scoreboard bench for the TMDS lane decoder
module tb_ibis_tmds_decoder;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic       aclk = 1'b0;
  logic       areset;
  logic       enable;
  logic [9:0] in_parallel;
  logic       bitslip;
  logic       locked;
  logic [7:0] data;
  logic       data_enable;
  logic [1:0] control;
  logic [1:0] debug_state;

  always #5 aclk = ~aclk;

  ibis_tmds_decoder dut (
    .aclk        (aclk),
    .areset      (areset),
    .enable      (enable),
    .in_parallel (in_parallel),
    .bitslip     (bitslip),
    .locked      (locked),
    .data        (data),
    .data_enable (data_enable),
    .control     (control),
    .debug_state (debug_state)
  );

  typedef struct {
    logic [7:0] b;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   slip_cyc[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   en_edges = 0;
  int   slip_cnt = 0;
  int   off_base = 0;

  logic       mon_e, mon_r;
  exp_t       mon_x;
  logic [7:0] prev_data;
  logic       prev_de, prev_locked;
  logic [1:0] prev_ctrl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [9:0] rot10(input logic [9:0] w, input int s);
    logic [19:0] t;
    t = {w, w} >> s;
    return t[9:0];
  endfunction

  // Reference encoder choosing the inversion and XOR/XNOR chaining explicitly
  function automatic logic [9:0] enc(input logic [7:0] d, input bit inv, input bit xnr);
    logic [7:0] m;
    m[0] = d[0];
    for (int i = 1; i < 8; i++) m[i] = xnr ? ~(d[i] ^ m[i-1]) : (d[i] ^ m[i-1]);
    return {inv, ~xnr, inv ? ~m : m};
  endfunction

  task automatic set_off(input int o);
    off_base = (((o - slip_cnt) % 10) + 10) % 10;
  endtask

  task automatic drive(input logic [9:0] w, input logic en);
    @(negedge aclk);
    in_parallel = rot10(w, (off_base + slip_cnt) % 10);
    enable      = en;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit inv, input bit xnr,
                           input logic en, input bit push);
    drive(enc(b, inv, xnr), en);
    if (push && en) sb.push_back('{b, en_edges + 2});
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1;
    @(posedge aclk);
    #2;
    areset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_locked"},  32'(locked),      32'd0);
    check({tag, "_de"},      32'(data_enable), 32'd0);
    check({tag, "_data"},    32'(data),        32'd0);
    check({tag, "_control"}, 32'(control),     32'd0);
    check({tag, "_bitslip"}, 32'(bitslip),     32'd0);
    check({tag, "_state"},   32'(debug_state), 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a decoded byte
  always @(posedge aclk) begin
    mon_e = enable;
    mon_r = areset;
    #1;
    cyc++;
    if (!mon_r) begin
      if (!mon_e) begin
        check("freeze_data",   32'(data),        32'(prev_data));
        check("freeze_de",     32'(data_enable), 32'(prev_de));
        check("freeze_ctrl",   32'(control),     32'(prev_ctrl));
        check("freeze_locked", 32'(locked),      32'(prev_locked));
      end else begin
        en_edges++;
        while (sb.size() > 0 && sb[0].due < en_edges) begin
          checks++;
          failures++;
          $display("FAIL sb_missing byte=%0h due=%0d now=%0d", sb[0].b, sb[0].due, en_edges);
          void'(sb.pop_front());
        end
        if (data_enable) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected actual=%0h expected=none", data);
          end else begin
            mon_x = sb.pop_front();
            check("sb_data",    32'(data),     32'(mon_x.b));
            check("sb_latency", 32'(en_edges), 32'(mon_x.due));
          end
        end
        if (bitslip) begin
          slip_cnt++;
          slip_cyc.push_back(cyc);
        end
      end
    end
    prev_data   = data;
    prev_de     = data_enable;
    prev_ctrl   = control;
    prev_locked = locked;
  end

  initial begin
    int   n;
    int   base;
    int   idx0;
    int   rcyc;
    logic [7:0] bytes [4];
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55; bytes[3] = 8'hA5;

    areset      = 1'b1;
    enable      = 1'b1;
    in_parallel = 10'h000;
    repeat (3) @(posedge aclk);
    #2;
    check_reset_outputs("rst");
    areset = 1'b0;

    // Aligned stream: lock after the 8th token, then decode in all four coding modes
    for (int i = 0; i < 8; i++) drive(T00, 1'b1);
    @(posedge aclk); #2;
    check("lock_before_8th", 32'(locked), 32'd0);
    drive(T00, 1'b1);
    @(posedge aclk); #2;
    check("lock_at_8th",  32'(locked),      32'd1);
    check("state_locked", 32'(debug_state), 32'd2);
    check("de_on_token",  32'(data_enable), 32'd0);
    for (int i = 0; i < 3; i++) drive(T00, 1'b1);
    for (int md = 0; md < 4; md++)
      for (int b = 0; b < 4; b++) send_byte(bytes[b], md[1], md[0], 1'b1, 1'b1);

    // Control tokens in blanking; data holds across tokens, control holds across data
    drive(T01, 1'b1); drive(T01, 1'b1);
    @(posedge aclk); #2;
    check("ctrl_01",         32'(control), 32'd1);
    check("data_hold_token", 32'(data),    32'hA5);
    drive(T10, 1'b1); drive(T10, 1'b1);
    @(posedge aclk); #2;
    check("ctrl_10", 32'(control), 32'd2);
    drive(T11, 1'b1); drive(T11, 1'b1);
    @(posedge aclk); #2;
    check("ctrl_11", 32'(control), 32'd3);
    for (int i = 0; i < 4; i++) send_byte(8'h3C ^ 8'(i), i[0], i[1], 1'b1, 1'b1);
    @(posedge aclk); #2;
    check("ctrl_hold_data", 32'(control), 32'd3);

    // Alternating enable: frozen outputs on disabled edges, latency in enabled edges
    for (int i = 0; i < 6; i++) begin
      send_byte(8'h90 + 8'(i), 1'b0, i[0], 1'b1, 1'b1);
      send_byte(8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // Loss of lock after LOSS_TIMEOUT data words with no token; no slip requested
    base = slip_cnt;
    drive(T00, 1'b1);
    for (int k = 0; k < 65536; k++) send_byte(bytes[k % 4], k[2], k[3], 1'b1, 1'b1);
    @(posedge aclk); #2;
    check("loss_still_locked", 32'(locked), 32'd1);
    send_byte(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge aclk); #2;
    check("loss_dropped",  32'(locked),      32'd0);
    check("loss_state",    32'(debug_state), 32'd0);
    check("loss_no_slip",  32'(slip_cnt),    32'(base));

    // Stream rotated by 3 bits; deserialiser model rotates on each bitslip pulse
    do_reset();
    set_off(7);
    base = slip_cnt;
    idx0 = slip_cyc.size();
    n    = 0;
    while (!locked && n < 8000) begin
      drive(T00, 1'b1);
      n++;
    end
    check("slip_locked", 32'(locked),          32'd1);
    check("slip_count",  32'(slip_cnt - base), 32'd3);
    for (int j = 1; j < 3; j++)
      if (slip_cyc.size() > idx0 + j)
        check("slip_gap", 32'(slip_cyc[idx0 + j] - slip_cyc[idx0 + j - 1]), 32'd2064);
    drive(T00, 1'b1);
    for (int b = 0; b < 4; b++) send_byte(bytes[b], b[0], b[1], 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(T11, 1'b1);

    // Reset from a locked state with control=11, then reset one cycle after a slip pulse
    do_reset();
    check_reset_outputs("rst_locked");
    set_off(5);
    base = slip_cnt;
    n    = 0;
    while (slip_cnt == base && n < 3000) begin
      drive(T00, 1'b1);
      n++;
    end
    check("first_slip_seen", 32'(slip_cnt - base), 32'd1);
    areset = 1'b1;
    @(posedge aclk); #2;
    rcyc   = cyc;
    areset = 1'b0;
    check_reset_outputs("rst_slipwait");
    base = slip_cnt;
    n    = 0;
    while (slip_cnt == base && n < 2200) begin
      drive(T00, 1'b1);
      n++;
    end
    check("fresh_slip_seen", 32'(slip_cnt - base), 32'd1);
    if (slip_cyc.size() > 0)
      check("fresh_slip_delay", 32'(slip_cyc[slip_cyc.size() - 1] - rcyc), 32'd2048);
    repeat (3) drive(T00, 1'b1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
